mem_wb_hilo: RTL and testbench

Receiving end of the memory-stage result interface: the MEM/WB pipeline register and the architected HI/LO register pair. It captures the write-back bundle from the memory stage each cycle, holds or bubbles it under stall control, and drives the general-register write port. It commits HI/LO writes one cycle later and supplies forwarded HI/LO values to the execute stage so MFHI/MFLO read the newest value without a stall.

---
 rtl/mem_wb_hilo_if.sv | 49 ++++
 rtl/mem_wb_hilo.sv | 90 +++++++++
 tb/tb_mem_wb_hilo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_hilo_if.sv
// ---------------------------------------------------------------------------
// mem_wb_hilo_if
// Bundle between the memory stage and the MEM/WB + HI/LO block.
//   master : memory stage side; drives the mem_* bundle and stall controls,
//            observes the registered write-back, HI/LO and forwarding values.
//   slave  : mem_wb_hilo side; the mirror image of master.
// Signals:
//   mem_wdata/mem_wd/mem_wreg   general register write request
//   mem_whilo/mem_hi/mem_lo     HI/LO write request
//   stall_mem/stall_wb          pipeline stall controls
//   wb_*                        registered write-back bundle
//   hi_o/lo_o                   architected HI/LO
//   fwd_hi/fwd_lo               newest HI/LO for the execute stage
// ---------------------------------------------------------------------------
interface mem_wb_hilo_if;
   logic [31:0] mem_wdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic        stall_mem;
   logic        stall_wb;

   logic [31:0] wb_wdata;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic        wb_whilo;
   logic [31:0] wb_hi;
   logic [31:0] wb_lo;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [31:0] fwd_hi;
   logic [31:0] fwd_lo;

   modport master (
      output mem_wdata, mem_wd, mem_wreg, mem_whilo, mem_hi, mem_lo,
             stall_mem, stall_wb,
      input  wb_wdata, wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo,
             hi_o, lo_o, fwd_hi, fwd_lo
   );

   modport slave (
      input  mem_wdata, mem_wd, mem_wreg, mem_whilo, mem_hi, mem_lo,
             stall_mem, stall_wb,
      output wb_wdata, wb_wd, wb_wreg, wb_whilo, wb_hi, wb_lo,
             hi_o, lo_o, fwd_hi, fwd_lo
   );
endinterface

// File: rtl/mem_wb_hilo.sv
// ---------------------------------------------------------------------------
// mem_wb_hilo
// MEM/WB pipeline register plus the architected HI/LO pair.
// Ports:
//   clk  pipeline clock, rising edge
//   rst  synchronous active-high reset, overrides everything
//   bus  mem_wb_hilo_if.slave: mem_* bundle and stalls in, wb_* bundle,
//        hi_o/lo_o and combinational fwd_hi/fwd_lo out
// ---------------------------------------------------------------------------
module mem_wb_hilo (
   input  logic          clk,
   input  logic          rst,
   mem_wb_hilo_if.slave  bus
);
   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam logic [RegAddrBus-1:0] NopRegAddr = '0;

   logic [RegBus-1:0]     r_wdata;
   logic [RegAddrBus-1:0] r_wd;
   logic                  r_wreg;
   logic                  r_whilo;
   logic [RegBus-1:0]     r_hi;
   logic [RegBus-1:0]     r_lo;
   logic [RegBus-1:0]     r_archHi;
   logic [RegBus-1:0]     r_archLo;
   logic [RegBus-1:0]     w_fwdHi;
   logic [RegBus-1:0]     w_fwdLo;

   // Pipeline latch. A stalled memory stage with a running write-back stage
   // must insert a bubble, otherwise the stalled instruction would be
   // written back a second time on the following edge.
   always_ff @(posedge clk) begin
      if (rst || (bus.stall_mem && !bus.stall_wb)) begin
         r_wdata <= '0;
         r_wd    <= NopRegAddr;
         r_wreg  <= 1'b0;
         r_whilo <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (!bus.stall_wb) begin
         r_wdata <= bus.mem_wdata;
         r_wd    <= bus.mem_wd;
         r_wreg  <= bus.mem_wreg;
         r_whilo <= bus.mem_whilo;
         r_hi    <= bus.mem_hi;
         r_lo    <= bus.mem_lo;
      end
   end

   // HI/LO commit. Gating on stall_wb keeps a held latch from committing the
   // same instruction on every stalled edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_archHi <= '0;
         r_archLo <= '0;
      end else if (r_whilo && !bus.stall_wb) begin
         r_archHi <= r_hi;
         r_archLo <= r_lo;
      end
   end

   // Forwarding picks the youngest pending HI/LO writer; reset forces zero
   // so the execute stage never sees stale or undefined state during reset.
   always_comb begin
      w_fwdHi = r_archHi;
      w_fwdLo = r_archLo;
      if (rst) begin
         w_fwdHi = '0;
         w_fwdLo = '0;
      end else if (bus.mem_whilo) begin
         w_fwdHi = bus.mem_hi;
         w_fwdLo = bus.mem_lo;
      end else if (r_whilo) begin
         w_fwdHi = r_hi;
         w_fwdLo = r_lo;
      end
   end

   assign bus.wb_wdata = r_wdata;
   assign bus.wb_wd    = r_wd;
   assign bus.wb_wreg  = r_wreg;
   assign bus.wb_whilo = r_whilo;
   assign bus.wb_hi    = r_hi;
   assign bus.wb_lo    = r_lo;
   assign bus.hi_o     = r_archHi;
   assign bus.lo_o     = r_archLo;
   assign bus.fwd_hi   = w_fwdHi;
   assign bus.fwd_lo   = w_fwdLo;
endmodule

// File: tb/tb_mem_wb_hilo.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_hilo
// Self-checking bench for mem_wb_hilo: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_mem_wb_hilo;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_wb_hilo_if busIf ();

   mem_wb_hilo dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf.slave)
   );

   typedef struct {
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic        wreg;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
   } wbBundle_t;

   wbBundle_t   modelWb;
   logic [31:0] modelHi;
   logic [31:0] modelLo;
   bit          modelValid = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs (called just after a falling edge), checks
   // the combinational forwarding, advances the model over the rising edge,
   // then checks every registered output at the next falling edge.
   task automatic applyStimulus(input logic r, input logic sm, input logic sw,
                                input logic wreg, input logic [4:0] wd,
                                input logic [31:0] wdata, input logic whilo,
                                input logic [31:0] hi, input logic [31:0] lo);
      logic [31:0] expFwdHi;
      logic [31:0] expFwdLo;
      wbBundle_t   incoming;
      rst               = r;
      busIf.stall_mem   = sm;
      busIf.stall_wb    = sw;
      busIf.mem_wreg    = wreg;
      busIf.mem_wd      = wd;
      busIf.mem_wdata   = wdata;
      busIf.mem_whilo   = whilo;
      busIf.mem_hi      = hi;
      busIf.mem_lo      = lo;
      #1;
      if (modelValid) begin
         if (r) begin
            expFwdHi = 32'h0;
            expFwdLo = 32'h0;
         end else if (whilo) begin
            expFwdHi = hi;
            expFwdLo = lo;
         end else if (modelWb.whilo) begin
            expFwdHi = modelWb.hi;
            expFwdLo = modelWb.lo;
         end else begin
            expFwdHi = modelHi;
            expFwdLo = modelLo;
         end
         checkOutput("fwd_hi", busIf.fwd_hi, expFwdHi);
         checkOutput("fwd_lo", busIf.fwd_lo, expFwdLo);
      end
      @(posedge clk);
      incoming = '{wdata, wd, wreg, whilo, hi, lo};
      if (r) begin
         modelWb    = '{32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0};
         modelHi    = 32'h0;
         modelLo    = 32'h0;
         modelValid = 1'b1;
      end else begin
         if (modelWb.whilo && !sw) begin
            modelHi = modelWb.hi;
            modelLo = modelWb.lo;
         end
         if (!sw)
            modelWb = sm ? '{32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0} : incoming;
      end
      @(negedge clk);
      if (modelValid) begin
         checkOutput("wb_wdata", busIf.wb_wdata, modelWb.wdata);
         checkOutput("wb_wd",    {27'd0, busIf.wb_wd},    {27'd0, modelWb.wd});
         checkOutput("wb_wreg",  {31'd0, busIf.wb_wreg},  {31'd0, modelWb.wreg});
         checkOutput("wb_whilo", {31'd0, busIf.wb_whilo}, {31'd0, modelWb.whilo});
         checkOutput("wb_hi",    busIf.wb_hi, modelWb.hi);
         checkOutput("wb_lo",    busIf.wb_lo, modelWb.lo);
         checkOutput("hi_o",     busIf.hi_o,  modelHi);
         checkOutput("lo_o",     busIf.lo_o,  modelLo);
      end
   endtask

   task automatic idleCycle(input logic sw);
      applyStimulus(1'b0, 1'b0, sw, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic hiloWrite(input logic [31:0] hi, input logic [31:0] lo);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, hi, lo);
   endtask

   initial begin
      rst = 1'b1;
      busIf.stall_mem = 1'b0;
      busIf.stall_wb  = 1'b0;
      busIf.mem_wreg  = 1'b0;
      busIf.mem_wd    = 5'd0;
      busIf.mem_wdata = 32'h0;
      busIf.mem_whilo = 1'b0;
      busIf.mem_hi    = 32'h0;
      busIf.mem_lo    = 32'h0;
      @(negedge clk);

      $display("[TB] reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b1,
                    32'h1, 32'h2);
      checkOutput("rstHi", busIf.hi_o, 32'h0);

      $display("[TB] register write");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 1'b0,
                    32'h0, 32'h0);
      checkOutput("planWdata", busIf.wb_wdata, 32'h1234_5678);
      checkOutput("planWd", {27'd0, busIf.wb_wd}, 32'd3);

      $display("[TB] hi/lo write latency");
      hiloWrite(32'hAAAA_0001, 32'h5555_0002);
      checkOutput("planWbHi", busIf.wb_hi, 32'hAAAA_0001);
      idleCycle(1'b0);
      checkOutput("planHi", busIf.hi_o, 32'hAAAA_0001);
      checkOutput("planLo", busIf.lo_o, 32'h5555_0002);

      $display("[TB] back-to-back hi/lo writes");
      hiloWrite(32'd1, 32'd11);
      checkOutput("b2bWbHi", busIf.wb_hi, 32'd1);
      hiloWrite(32'd2, 32'd12);
      idleCycle(1'b0);
      checkOutput("b2bHi", busIf.hi_o, 32'd2);
      idleCycle(1'b0);

      $display("[TB] bubble");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0,
                    32'h0, 32'h0);
      checkOutput("bubbleWreg", {31'd0, busIf.wb_wreg}, 32'd0);

      $display("[TB] write-back stall");
      hiloWrite(32'd7, 32'd17);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h55, 1'b1,
                       32'h99, 32'h98);
         checkOutput("stallHi", busIf.hi_o, 32'd2);
      end
      idleCycle(1'b0);
      checkOutput("releaseHi", busIf.hi_o, 32'd7);

      $display("[TB] reset discards pending commit");
      hiloWrite(32'd9, 32'd19);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
      checkOutput("rstMidHi", busIf.hi_o, 32'd0);
      idleCycle(1'b0);
      checkOutput("rstAfterHi", busIf.hi_o, 32'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(39) == 0),
                       ($urandom_range(4) == 0),
                       ($urandom_range(4) == 0),
                       1'($urandom),
                       5'($urandom),
                       $urandom,
                       ($urandom_range(2) == 0),
                       $urandom,
                       $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
